jackpot_controller: RTL
=======================

Name: jackpot_controller

Overview:
Game core of the jackpot game. It consumes the one-cycle slow tick derived from the clock divider and rotates a single lit LED across the LED bank. The player flips the switch under the lit LED. A hit enters a flashing WIN sequence and increments a score; a wrong switch is counted as a miss. The whole block runs on the board clock, with the tick used as an enable and never as a clock.

Parameters:
N_LEDS, 4, number of LEDs and switches; must be at least 2.
WIN_TICKS, 8, length of the WIN flash in ticks; must be even and at least 2.
SCORE_W, 8, width of the saturating win counter.

Ports:
CLOCK  input  1  board clock; all state changes on its rising edge.
RESET_N  input  1  asynchronous, active-low reset.
TICK  input  1  one-CLOCK-cycle enable pulse from the divider stage.
SWITCHES  input  N_LEDS  raw asynchronous slide switches.
LEDS  output  N_LEDS  LED drive.
WIN  output  1  high while in the WIN state.
MISS  output  1  one-cycle pulse on a wrong switch.
SCORE  output  SCORE_W  number of wins, saturating.

Behaviour:
- Reset (RESET_N low, asynchronous) sets these values:
  - state = SPIN, LEDS = one-hot bit 0, WIN = 0, MISS = 0, SCORE = 0, flash counter = 0.
  - Synchroniser and edge registers are cleared to 0.
- Switch input path:
  - Each SWITCHES bit passes through a 2-flop synchroniser, then a previous-value register.
  - edge[i] = sync[i] & ~prev[i].
  - A switch toggle becomes visible as edge 2 CLOCK cycles after it is captured.
  - Only rising edges count. Holding a switch high does nothing; falling edges are ignored.
- State SPIN:
  - On TICK, LEDS rotates left by one. The top bit wraps to bit 0: 0001→0010→0100→1000→0001.
  - Decision is taken in a cycle where edge != 0:
    - Hit: edge equals LEDS exactly (one edge, on the lit position). Next state is WIN, LEDS = all ones, flash counter = 0, SCORE increments and saturates at all ones.
    - Miss: any other nonzero edge, including multiple simultaneous edges or an edge plus the lit bit. MISS pulses high for exactly 1 cycle (registered, next cycle). State stays SPIN and LEDS is unaffected by the miss.
  - Edge and TICK in the same cycle: the decision compares against the current, pre-rotation LEDS. A hit takes priority over the rotation. On a miss the rotation still happens.
- State WIN:
  - WIN = 1.
  - Edges are ignored: no MISS, no SCORE change.
  - On each TICK: if flash counter == WIN_TICKS-1, go to SPIN with LEDS = one-hot bit 0 and counter = 0. Otherwise invert LEDS and increment the counter.
  - LEDS pattern over the sequence: on, off, ..., off; exit after WIN_TICKS ticks.
- WIN output latency: WIN asserts on the clock edge after the decision cycle. SCORE updates on that same edge.
- TICK is level-sampled. Back-to-back TICK cycles each advance the sequence; the block does not require ticks to be sparse.
- Reset mid-WIN or mid-synchroniser returns immediately to the reset values. A switch already high at reset release produces an edge once synchronised, and is treated as a normal hit or miss.

Decomposition:
- Package jackpot_pkg holds:
  - the state enum {SPIN, WIN};
  - default N_LEDS;
  - the LED_START constant (one-hot bit 0) and the ALL_ON constant;
  - the counter width function clog2(WIN_TICKS).
- Sub-module switch_sync_edge (parameter WIDTH; ports CLOCK, RESET_N, d, edge). It contains the 2-flop synchroniser plus the previous register and is instantiated once with WIDTH = N_LEDS.
- The FSM, rotator, flash counter and score counter live in jackpot_controller.

Test Plan:
- Reset, then 5 TICK pulses spaced 10 cycles apart → LEDS goes 0001, 0010, 0100, 1000, 0001, 0010. WIN = 0, SCORE = 0.
- LEDS = 0100, raise SWITCHES[2] → 3 cycles later WIN = 1, LEDS = 1111, SCORE = 1. Then 8 TICKs → LEDS alternates 0000/1111. On the 8th tick LEDS = 0001 and WIN = 0.
- LEDS = 0010, raise SWITCHES[3]; separately raise SWITCHES[1] and [2] in the same cycle → one MISS pulse for each event. SCORE is unchanged and rotation continues.
- Switch edge on the lit LED coinciding with TICK (LEDS = 1000, SWITCHES[3] rising, TICK in the edge cycle) → hit is registered (WIN = 1), with no rotation to 0001 first.
- SCORE_W = 2: 4 consecutive hits → SCORE goes 1, 2, 3, 3 (saturates).
- Switch rising during WIN, then RESET_N pulsed low mid-WIN → no MISS and no SCORE change from the switch. After reset: LEDS = 0001, WIN = 0, SCORE = 0, immediately and asynchronously.

Source files
------------

// File: rtl/jackpot_pkg.sv
// Shared types and constants for the jackpot game core.
//   state_t    : game FSM states
//   LED_START  : one-hot bit 0, the LED pattern at reset and after a WIN
//   ALL_ON     : every LED lit, the first frame of the WIN flash
//   clog2()    : width of the WIN flash counter
package jackpot_pkg;

    typedef enum logic {
        ST_SPIN = 1'b0,
        ST_WIN  = 1'b1
    } state_t;

    localparam int N_LEDS_DEFAULT = 4;

    // Sized to the widest supported bank; users slice down to N_LEDS.
    localparam int MAX_LEDS = 32;
    localparam logic [MAX_LEDS-1:0] LED_START = MAX_LEDS'(1);
    localparam logic [MAX_LEDS-1:0] ALL_ON    = '1;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/jackpot_controller_switch_sync_edge.sv
// Switch conditioning: 2-flop synchroniser followed by a previous-value
// register, producing a one-cycle pulse per rising edge of each bit.
//   CLOCK   : board clock
//   RESET_N : asynchronous active-low reset
//   d       : raw asynchronous switch inputs
//   edge_o  : rising-edge pulses, valid two cycles after capture
module switch_sync_edge #(
    parameter int WIDTH = 4
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] edge_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/jackpot_controller.sv
// Jackpot game core. A single lit LED rotates on each TICK; a rising
// switch edge on exactly the lit position is a hit (WIN flash, SCORE+1),
// any other rising edge pattern is a miss (one-cycle MISS pulse).
//   CLOCK    : board clock
//   RESET_N  : asynchronous active-low reset
//   TICK     : one-cycle enable from the divider, level-sampled
//   SWITCHES : raw slide switches
//   LEDS     : LED drive
//   WIN      : high while in the WIN flash
//   MISS     : one-cycle pulse per wrong switch event
//   SCORE    : saturating win count
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_SPIN | one-hot LED rotates on TICK, switch edges are judged
// ST_WIN  | LEDS toggle all-on/all-off on TICK for WIN_TICKS ticks
module jackpot_controller
    import jackpot_pkg::*;
#(
    parameter int N_LEDS    = N_LEDS_DEFAULT,
    parameter int WIN_TICKS = 8,
    parameter int SCORE_W   = 8
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               TICK,
    input  logic [N_LEDS-1:0]  SWITCHES,
    output logic [N_LEDS-1:0]  LEDS,
    output logic               WIN,
    output logic               MISS,
    output logic [SCORE_W-1:0] SCORE
);

    localparam int CNT_W = clog2(WIN_TICKS);
    localparam logic [N_LEDS-1:0]  LEDS_INIT = LED_START[N_LEDS-1:0];
    localparam logic [N_LEDS-1:0]  LEDS_ALL  = ALL_ON[N_LEDS-1:0];
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(WIN_TICKS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [N_LEDS-1:0] sw_edge;

    state_t             state_q, state_d;
    logic [N_LEDS-1:0]  leds_q, leds_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               win_q, win_d;
    logic               miss_q, miss_d;

    switch_sync_edge #(
        .WIDTH (N_LEDS)
    ) u_sync (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .d       (SWITCHES),
        .edge_o  (sw_edge)
    );

    always_comb begin
        state_d = state_q;
        leds_d  = leds_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        miss_d  = 1'b0;

        case (state_q)
            ST_SPIN: begin
                // Judged against the pre-rotation LEDS; a hit suppresses
                // the rotation, a miss does not.
                if ((sw_edge != '0) && (sw_edge == leds_q)) begin
                    state_d = ST_WIN;
                    leds_d  = LEDS_ALL;
                    cnt_d   = '0;
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end else begin
                    if (sw_edge != '0) begin
                        miss_d = 1'b1;
                    end
                    if (TICK) begin
                        leds_d = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
                    end
                end
            end
            ST_WIN: begin
                if (TICK) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_SPIN;
                        leds_d  = LEDS_INIT;
                        cnt_d   = '0;
                    end else begin
                        leds_d = ~leds_q;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase

        win_d = (state_d == ST_WIN);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_SPIN;
            leds_q  <= LEDS_INIT;
            cnt_q   <= '0;
            score_q <= '0;
            win_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            leds_q  <= leds_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            win_q   <= win_d;
            miss_q  <= miss_d;
        end
    end

    assign LEDS  = leds_q;
    assign WIN   = win_q;
    assign MISS  = miss_q;
    assign SCORE = score_q;

endmodule
